// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SLC-3 SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  localparam int WAIT_CYC_DEF = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (CPU, debug) and SRAM bus bundle for mem_arbiter; slave = arbiter view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              CPU_Req;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_Addr;
  logic [DATA_W-1:0] CPU_WData;
  logic              CPU_Ack;
  logic [DATA_W-1:0] CPU_RData;

  logic              DBG_Req;
  logic              DBG_WE;
  logic [ADDR_W-1:0] DBG_Addr;
  logic [DATA_W-1:0] DBG_WData;
  logic              DBG_Ack;
  logic [DATA_W-1:0] DBG_RData;

  logic [ADDR_W-1:0] SRAM_Addr;
  logic [DATA_W-1:0] SRAM_WData;
  logic [DATA_W-1:0] SRAM_RData;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_Data_OE;
  logic              Busy;

  modport slave (
    input  CPU_Req, CPU_WE, CPU_Addr, CPU_WData,
    input  DBG_Req, DBG_WE, DBG_Addr, DBG_WData,
    input  SRAM_RData,
    output CPU_Ack, CPU_RData, DBG_Ack, DBG_RData,
    output SRAM_Addr, SRAM_WData, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_Data_OE,
    output Busy
  );

  modport master (
    output CPU_Req, CPU_WE, CPU_Addr, CPU_WData,
    output DBG_Req, DBG_WE, DBG_Addr, DBG_WData,
    output SRAM_RData,
    input  CPU_Ack, CPU_RData, DBG_Ack, DBG_RData,
    input  SRAM_Addr, SRAM_WData, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_Data_OE,
    input  Busy
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with zero flag, used to time the SRAM strobe window.
module mem_arb_timer #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter/sequencer. Define MEM_ARB_RR_EN for round-robin tie-break;
// otherwise CPU has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input logic           Clk,
  input logic           Reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_e      state_q, state_d;
  port_e       owner_q, owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d;
  logic        cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
  logic        tmr_load, tmr_en, tmr_zero, grant_dbg;

  mem_arb_timer #(.W(CNT_W)) u_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .load_val_i(CNT_LOAD),
    .zero_o    (tmr_zero)
  );

`ifdef MEM_ARB_RR_EN
  // owner_q doubles as the most-recent-owner record for the tie-break
  assign grant_dbg = bus.DBG_Req && (!bus.CPU_Req || owner_q == PORT_CPU);
`else
  assign grant_dbg = bus.DBG_Req && !bus.CPU_Req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CPU_Req || bus.DBG_Req) begin
          state_d  = ACCESS;
          tmr_load = 1'b1;
          owner_d  = grant_dbg ? PORT_DBG : PORT_CPU;
          we_d     = grant_dbg ? bus.DBG_WE    : bus.CPU_WE;
          addr_d   = grant_dbg ? bus.DBG_Addr  : bus.CPU_Addr;
          wdata_d  = grant_dbg ? bus.DBG_WData : bus.CPU_WData;
        end
      end
      ACCESS: begin
        if (tmr_zero) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == PORT_DBG) dbg_rdata_d = bus.SRAM_RData;
            else                     cpu_rdata_d = bus.SRAM_RData;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes and acks are decoded from the next state so the outputs are registered
    ce_n_d    = (state_d != ACCESS);
    oe_n_d    = !(state_d == ACCESS && !we_d);
    we_n_d    = !(state_d == ACCESS && we_d);
    doe_d     = (state_d == ACCESS && we_d);
    cpu_ack_d = (state_d == DONE && owner_d == PORT_CPU);
    dbg_ack_d = (state_d == DONE && owner_d == PORT_DBG);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= PORT_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      doe_q       <= doe_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign bus.SRAM_Addr    = addr_q;
  assign bus.SRAM_WData   = wdata_q;
  assign bus.SRAM_CE_N    = ce_n_q;
  assign bus.SRAM_OE_N    = oe_n_q;
  assign bus.SRAM_WE_N    = we_n_q;
  assign bus.SRAM_Data_OE = doe_q;
  assign bus.CPU_Ack      = cpu_ack_q;
  assign bus.DBG_Ack      = dbg_ack_q;
  assign bus.CPU_RData    = cpu_rdata_q;
  assign bus.DBG_RData    = dbg_rdata_q;
  assign bus.Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int WC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.WAIT_CYC(WC)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    port_e       port;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.CPU_Ack || bus.DBG_Ack)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=cpu%0b_dbg%0b required=none", bus.CPU_Ack, bus.DBG_Ack);
      end else begin
        e = sb_q.pop_front();
        check("ack_both", {31'd0, bus.CPU_Ack & bus.DBG_Ack}, 32'd0);
        check("ack_port", {31'd0, bus.DBG_Ack}, {31'd0, e.port == PORT_DBG});
        check("ack_rdata", {16'd0, (e.port == PORT_DBG) ? bus.DBG_RData : bus.CPU_RData},
              {16'd0, e.rdata});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input port_e p, input logic r, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
    if (p == PORT_CPU) begin
      bus.CPU_Req = r; bus.CPU_WE = we; bus.CPU_Addr = addr; bus.CPU_WData = wdata;
    end else begin
      bus.DBG_Req = r; bus.DBG_WE = we; bus.DBG_Addr = addr; bus.DBG_WData = wdata;
    end
  endtask

  task automatic do_access(input port_e p, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rd,
                           input logic [15:0] exp_rd);
    int strobe_cnt = 0;
    int doe_cnt    = 0;
    int ack_at     = -1;
    logic [15:0] addr_seen  = 16'hFFFF;
    logic [15:0] wdata_seen = 16'hFFFF;
    sb_q.push_back('{p, exp_rd});
    bus.SRAM_RData = rd;
    set_req(p, 1'b1, we, addr, wdata);
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      @(negedge clk);
      if (we ? !bus.SRAM_WE_N : !bus.SRAM_OE_N) strobe_cnt++;
      if (bus.SRAM_Data_OE) doe_cnt++;
      if (!bus.SRAM_CE_N) begin
        addr_seen  = bus.SRAM_Addr;
        wdata_seen = bus.SRAM_WData;
      end
      if (bus.CPU_Ack || bus.DBG_Ack) ack_at = i;
    end
    set_req(p, 1'b0, 1'b0, 16'h0, 16'h0);
    check("ack_latency", ack_at, WC + 1);
    check("strobe_cycles", strobe_cnt, WC);
    check("data_oe_cycles", doe_cnt, we ? WC : 0);
    check("sram_addr", {16'd0, addr_seen}, {16'd0, addr});
    if (we) check("sram_wdata", {16'd0, wdata_seen}, {16'd0, wdata});
    @(posedge clk); #1;
  endtask

  initial begin
    int n_ack;
    int n_dbg;
    int last_at;
    port_e exp_seq [4];

    set_req(PORT_CPU, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(PORT_DBG, 1'b0, 1'b0, 16'h0, 16'h0);
    bus.SRAM_RData = 16'h0;

    // Reset values
    #12;
    check("rst_ce_n", {31'd0, bus.SRAM_CE_N}, 32'd1);
    check("rst_oe_n", {31'd0, bus.SRAM_OE_N}, 32'd1);
    check("rst_we_n", {31'd0, bus.SRAM_WE_N}, 32'd1);
    check("rst_data_oe", {31'd0, bus.SRAM_Data_OE}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_acks", {30'd0, bus.CPU_Ack, bus.DBG_Ack}, 32'd0);
    check("rst_addr", {16'd0, bus.SRAM_Addr}, 32'd0);
    check("rst_rdata", {bus.CPU_RData, bus.DBG_RData}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // CPU read, CPU write, DBG read
    do_access(PORT_CPU, 1'b0, 16'h0030, 16'h0000, 16'h1234, 16'h1234);
    do_access(PORT_CPU, 1'b1, 16'h0041, 16'hBEEF, 16'hDEAD, 16'h1234);
    check("cpu_rdata_after_write", {16'd0, bus.CPU_RData}, 32'h1234);
    do_access(PORT_DBG, 1'b0, 16'h0005, 16'h0000, 16'h5A5A, 16'h5A5A);
    check("cpu_rdata_after_dbg", {16'd0, bus.CPU_RData}, 32'h1234);

    // Reset in the second ACCESS cycle
    bus.SRAM_RData = 16'h9999;
    set_req(PORT_CPU, 1'b1, 1'b0, 16'h0030, 16'h0);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_oe_n", {31'd0, bus.SRAM_OE_N}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ce_n", {31'd0, bus.SRAM_CE_N}, 32'd1);
    check("mid_rst_oe_n", {31'd0, bus.SRAM_OE_N}, 32'd1);
    check("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("mid_rst_ack", {31'd0, bus.CPU_Ack}, 32'd0);
    set_req(PORT_CPU, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_rdata", {16'd0, bus.CPU_RData}, 32'd0);
    do_access(PORT_CPU, 1'b0, 16'h0030, 16'h0000, 16'h7777, 16'h7777);

    // Both requesters held from reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_seq = '{PORT_CPU, PORT_DBG, PORT_CPU, PORT_DBG};
`else
    exp_seq = '{PORT_CPU, PORT_CPU, PORT_CPU, PORT_CPU};
`endif
    foreach (exp_seq[k]) sb_q.push_back('{exp_seq[k], 16'h1111});
    bus.SRAM_RData = 16'h1111;
    set_req(PORT_CPU, 1'b1, 1'b0, 16'h0100, 16'h0);
    set_req(PORT_DBG, 1'b1, 1'b0, 16'h0200, 16'h0);
    n_ack = 0; n_dbg = 0; last_at = -1;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      @(negedge clk);
      if (bus.CPU_Ack || bus.DBG_Ack) begin
        if (bus.DBG_Ack) n_dbg++;
        if (last_at >= 0) check("grant_spacing", i - last_at, WC + 2);
        last_at = i;
        n_ack++;
      end
    end
    set_req(PORT_CPU, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(PORT_DBG, 1'b0, 1'b0, 16'h0, 16'h0);
    check("tie_ack_count", n_ack, 4);
`ifdef MEM_ARB_RR_EN
    check("tie_dbg_grants", n_dbg, 2);
`else
    check("tie_dbg_grants", n_dbg, 0);
`endif
    repeat (4) @(posedge clk);
    #1;
    check("tie_idle_busy", {31'd0, bus.Busy}, 32'd0);

    // DBG drops Req right after its grant
    sb_q.push_back('{PORT_DBG, 16'h2222});
    bus.SRAM_RData = 16'h2222;
    set_req(PORT_DBG, 1'b1, 1'b0, 16'h0007, 16'h0);
    @(posedge clk); #1;
    set_req(PORT_DBG, 1'b0, 1'b0, 16'h0, 16'h0);
    n_dbg = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.DBG_Ack) n_dbg++;
    end
    check("drop_dbg_acks", n_dbg, 1);
    check("drop_idle_busy", {31'd0, bus.Busy}, 32'd0);
    check("drop_cpu_rdata", {16'd0, bus.CPU_RData}, 32'h1111);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
